// File: rtl/fetch_pkg.sv
// Types and defaults shared by the instruction fetch front end.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetched {pc, inst} entries; flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  fetch_entry_t               push_entry_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output fetch_entry_t               head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // Empty FIFO presents zeros so the head reads 0 out of reset.
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues word reads and buffers results.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        dec_ready,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count;
  logic [CW-1:0] occ_after;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          xfer, deq, push, slot_free;
  logic          redir_lsb_unused;

  assign xfer       = mem_req && mem_ack;
  assign deq        = inst_valid && dec_ready;
  assign push       = (state_q == WAIT) && xfer && !redir_valid;
  assign occ_after  = count + CW'(push) - CW'(deq);
  assign slot_free  = occ_after < CW'(DEPTH);
  assign push_entry = '{pc: fetch_pc_q, inst: mem_rdata};
  assign redir_lsb_unused = ^redir_pc[1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redir_valid) begin
      fetch_pc_d = {redir_pc[31:2], 2'b00};
      unique case (state_q)
        IDLE:    state_d = WAIT;
        WAIT:    state_d = xfer ? WAIT : DROP;
        DROP:    state_d = xfer ? WAIT : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: if (slot_free) state_d = WAIT;
        WAIT: if (xfer) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = slot_free ? WAIT : IDLE;
        end
        DROP: if (xfer) state_d = WAIT;
        default: state_d = IDLE;
      endcase
    end
    // An outstanding request keeps its address until acked, even across redirects.
    addr_d = (!mem_req || mem_ack) ? fetch_pc_d : addr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_entry_i(push_entry),
    .pop_i       (deq),
    .flush_i     (redir_valid),
    .count_o     (count),
    .head_o      (head)
  );

  assign mem_req    = (state_q != IDLE);
  assign mem_addr   = addr_q;
  assign inst_valid = (count != '0);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: scripted memory responder plus an in-order PC scoreboard.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_3000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        dec_ready = 1'b1;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .dec_ready  (dec_ready),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int pop_cnt = 0;
  int xfer_cnt = 0;
  int lat = 0;
  bit ack_in_reset = 1'b0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_pc;
  } redir_vec_t;
  redir_vec_t vecs[4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic sb_load(input logic [31:0] start);
    sb_q.delete();
    for (int i = 0; i < 256; i++) sb_q.push_back(start + 32'(i * 4));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    sb_q.delete();
    tick(n);
    reset = 1'b0;
    sb_load(RPC);
  endtask

  task automatic wait_addr(input logic [31:0] a, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (mem_req && mem_addr == a) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: no request to %h within 60 cycles", name, a);
    end
  endtask

  task automatic wait_valid(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (inst_valid) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: inst_valid never rose within 60 cycles", name);
    end
  endtask

  // Scoreboard: every dequeue must match the next expected PC in program order.
  always @(negedge clock) begin
    logic [31:0] exp;
    if (!reset && inst_valid && dec_ready && !redir_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: dequeued pc %h with nothing expected", inst_pc);
      end else begin
        exp = sb_q.pop_front();
        check32("deq_pc", inst_pc, exp);
        check32("deq_inst", inst, mem_word(exp));
      end
      $display("deq pc=%h inst=%h", inst_pc, inst);
      pop_cnt++;
    end
  end

  // Memory responder with programmable wait states; also checks request stability.
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b1;
  logic [31:0] prev_addr = '0;
  int          wcnt = 0;
  always @(negedge clock) begin
    if (prev_req && !prev_ack && !prev_rst && !reset) begin
      checks++;
      if (!mem_req || mem_addr !== prev_addr) begin
        errors++;
        $display("FAIL req_hold: req=%b addr=%h expected req=1 addr=%h", mem_req, mem_addr, prev_addr);
      end
    end
    if (mem_req && mem_addr[1:0] != 2'b00) begin
      errors++;
      $display("FAIL addr_align: addr=%h expected low bits 00", mem_addr);
    end
    if (reset && ack_in_reset) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
    end else if (mem_req) begin
      if (wcnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        wcnt      = 0;
        if (!reset) xfer_cnt++;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
    prev_req  = mem_req;
    prev_ack  = mem_ack;
    prev_addr = mem_addr;
    prev_rst  = reset;
  end

  // FIFO overflow / underflow watch.
  always @(posedge clock) begin
    if (!reset && !dut.u_fifo.flush_i) begin
      if (dut.u_fifo.push_i && !dut.u_fifo.pop_i && int'(dut.u_fifo.count_o) == DEPTH) begin
        errors++;
        $display("FAIL overflow: push into full FIFO, count=%0d expected <%0d", dut.u_fifo.count_o, DEPTH);
      end
      if (dut.u_fifo.pop_i && dut.u_fifo.count_o == '0) begin
        errors++;
        $display("FAIL underflow: pop from empty FIFO, count=0 expected >0");
      end
    end
  end

  initial begin
    int p0, x0;
    vecs[0] = '{target: 32'h0000_3203, exp_pc: 32'h0000_3200};
    vecs[1] = '{target: 32'hFFFF_FFF8, exp_pc: 32'hFFFF_FFF8};
    vecs[2] = '{target: 32'h0000_0001, exp_pc: 32'h0000_0000};
    vecs[3] = '{target: 32'hFFFF_FFFF, exp_pc: 32'hFFFF_FFFC};

    // Reset values, first-fetch latency and full throughput.
    do_reset(3);
    check32("rst_mem_req", 32'(mem_req), 32'd0);
    check32("rst_mem_addr", mem_addr, RPC);
    check32("rst_inst_valid", 32'(inst_valid), 32'd0);
    check32("rst_inst", inst, 32'd0);
    check32("rst_inst_pc", inst_pc, 32'd0);
    tick(1);
    check32("c1_mem_req", 32'(mem_req), 32'd1);
    check32("c1_mem_addr", mem_addr, RPC);
    check32("c1_inst_valid", 32'(inst_valid), 32'd0);
    tick(1);
    check32("c2_inst_valid", 32'(inst_valid), 32'd1);
    check32("c2_inst_pc", inst_pc, RPC);
    check32("c2_inst", inst, mem_word(RPC));
    p0 = pop_cnt;
    tick(16);
    check32("throughput_pops", 32'(pop_cnt - p0), 32'd16);

    // Decode stall: fill exactly DEPTH entries, then resume without gaps.
    dec_ready = 1'b0;
    do_reset(2);
    x0 = xfer_cnt;
    tick(10);
    check32("stall_xfers", 32'(xfer_cnt - x0), 32'(DEPTH));
    check32("stall_mem_req", 32'(mem_req), 32'd0);
    check32("stall_inst_valid", 32'(inst_valid), 32'd1);
    check32("stall_head_pc", inst_pc, RPC);
    dec_ready = 1'b1;
    p0 = pop_cnt;
    tick(12);
    check32("resume_pops", 32'(pop_cnt - p0), 32'd12);

    // Slow memory: redirect while 3008 is outstanding.
    lat = 3;
    do_reset(2);
    wait_addr(32'h0000_3008, "find_3008");
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_3100;
    sb_load(32'h0000_3100);
    tick(1);
    redir_valid = 1'b0;
    check32("drop_mem_req", 32'(mem_req), 32'd1);
    check32("drop_mem_addr", mem_addr, 32'h0000_3008);
    check32("drop_inst_valid", 32'(inst_valid), 32'd0);
    wait_addr(32'h0000_3100, "find_3100");
    wait_valid("valid_3100");
    check32("first_pc_3100", inst_pc, 32'h0000_3100);

    // Redirect table: zero-wait memory, redirect coincides with ack and dequeue.
    lat = 0;
    tick(6);
    foreach (vecs[k]) begin
      check32("pre_redir_valid", 32'(inst_valid && mem_req), 32'd1);
      redir_valid = 1'b1;
      redir_pc    = vecs[k].target;
      sb_load(vecs[k].exp_pc);
      tick(1);
      redir_valid = 1'b0;
      check32("redir_n1_valid", 32'(inst_valid), 32'd0);
      check32("redir_n1_addr", mem_addr, vecs[k].exp_pc);
      tick(1);
      check32("redir_n2_valid", 32'(inst_valid), 32'd1);
      check32("redir_n2_pc", inst_pc, vecs[k].exp_pc);
      p0 = pop_cnt;
      tick(3);
      check32("redir_pops", 32'(pop_cnt - p0), 32'd3);
    end

    // Reset while in DROP, with memory acking during reset.
    lat = 3;
    do_reset(2);
    wait_addr(32'h0000_3004, "find_3004");
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_3400;
    sb_load(32'h0000_3400);
    tick(1);
    redir_valid = 1'b0;
    check32("drop2_mem_addr", mem_addr, 32'h0000_3004);
    ack_in_reset = 1'b1;
    reset = 1'b1;
    sb_q.delete();
    tick(2);
    reset = 1'b0;
    ack_in_reset = 1'b0;
    lat = 0;
    sb_load(RPC);
    check32("post_rst_addr", mem_addr, RPC);
    check32("post_rst_valid", 32'(inst_valid), 32'd0);
    wait_valid("valid_after_rst");
    check32("post_rst_first_pc", inst_pc, RPC);
    p0 = pop_cnt;
    tick(8);
    check32("post_rst_pops", 32'(pop_cnt - p0), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: bench still running at 200000 time units, expected to finish earlier");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
